// File: rtl/kb_entry_pkg.sv
// Shared key classes, FSM states and scan-code constants for keyboard number entry.
package kb_entry_pkg;

  typedef enum logic [2:0] {K_NONE, K_DIGIT, K_BKSP, K_ENTER, K_ESC} key_class_t;
  typedef enum logic [1:0] {S_ENTRY, S_CONV, S_HOLD} state_t;

  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Returns {hit, digit} for the top-row digit keys.
  function automatic logic [4:0] top_row_digit(input logic [7:0] sc);
    case (sc)
      8'h45:   return {1'b1, 4'd0};
      8'h16:   return {1'b1, 4'd1};
      8'h1E:   return {1'b1, 4'd2};
      8'h26:   return {1'b1, 4'd3};
      8'h25:   return {1'b1, 4'd4};
      8'h2E:   return {1'b1, 4'd5};
      8'h36:   return {1'b1, 4'd6};
      8'h3D:   return {1'b1, 4'd7};
      8'h3E:   return {1'b1, 4'd8};
      8'h46:   return {1'b1, 4'd9};
      default: return '0;
    endcase
  endfunction

  // Returns {hit, digit} for the numeric keypad digit keys.
  function automatic logic [4:0] keypad_digit(input logic [7:0] sc);
    case (sc)
      8'h70:   return {1'b1, 4'd0};
      8'h69:   return {1'b1, 4'd1};
      8'h72:   return {1'b1, 4'd2};
      8'h7A:   return {1'b1, 4'd3};
      8'h6B:   return {1'b1, 4'd4};
      8'h73:   return {1'b1, 4'd5};
      8'h74:   return {1'b1, 4'd6};
      8'h6C:   return {1'b1, 4'd7};
      8'h75:   return {1'b1, 4'd8};
      8'h7D:   return {1'b1, 4'd9};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/kb_key_classify.sv
// Combinational scan-code classifier: {extended, code} -> key class and digit value.
// Keypad digits and keypad Enter are recognised only when KB_KEYPAD_DIGITS_EN is defined.
module kb_key_classify
  import kb_entry_pkg::*;
(
  input  logic [8:0] last_change,
  output key_class_t key_class,
  output logic [3:0] digit
);

  logic [4:0] top_hit;
  logic [4:0] pad_hit;

  always_comb begin
    top_hit   = top_row_digit(last_change[7:0]);
    pad_hit   = keypad_digit(last_change[7:0]);
    key_class = K_NONE;
    digit     = '0;
    if (!last_change[8]) begin
      if (top_hit[4]) begin
        key_class = K_DIGIT;
        digit     = top_hit[3:0];
      end
`ifdef KB_KEYPAD_DIGITS_EN
      else if (pad_hit[4]) begin
        key_class = K_DIGIT;
        digit     = pad_hit[3:0];
      end
`endif
      else if (last_change[7:0] == SC_BKSP)  key_class = K_BKSP;
      else if (last_change[7:0] == SC_ENTER) key_class = K_ENTER;
      else if (last_change[7:0] == SC_ESC)   key_class = K_ESC;
    end
`ifdef KB_KEYPAD_DIGITS_EN
    else if (last_change[7:0] == SC_ENTER) begin
      key_class = K_ENTER;
    end
`endif
  end

endmodule

// File: rtl/kb_number_entry_ctrl.sv
// Keyboard digit entry: BCD entry buffer, serial BCD-to-binary conversion, valid/ready result.
// Optional KB_KEYPAD_DIGITS_EN (handled in kb_key_classify) adds numeric keypad keys.
module kb_number_entry_ctrl
  import kb_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int VAL_W      = 14
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               key_down_op,
  input  logic [8:0]                         last_change,
  input  logic                               out_ready,
  output logic [4*MAX_DIGITS-1:0]            disp_bcd,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_cnt,
  output logic                               busy,
  output logic                               overflow,
  output logic                               out_valid,
  output logic [VAL_W-1:0]                   out_value
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int BW = 4 * MAX_DIGITS;
  localparam logic [CW-1:0] FULL = CW'(MAX_DIGITS);

  state_t           state, state_n;
  logic [BW-1:0]    entry_q, entry_n, dig_ext, sel_shift;
  logic [CW-1:0]    cnt_q, cnt_n, idx_q, idx_n;
  logic [VAL_W-1:0] acc_q, acc_n, val_q, val_n;
  logic             ovf_q, ovf_n, valid_q, valid_n;
  logic [3:0]       cur_dig;
  key_class_t       kcls;
  logic [3:0]       kdig;

  kb_key_classify u_classify (
    .last_change (last_change),
    .key_class   (kcls),
    .digit       (kdig)
  );

  // Conversion walks from the most significant entered digit down to digit 0.
  always_comb begin
    sel_shift = entry_q >> {idx_q, 2'b00};
    cur_dig   = sel_shift[3:0];
  end

  always_comb begin
    state_n     = state;
    entry_n     = entry_q;
    cnt_n       = cnt_q;
    idx_n       = idx_q;
    acc_n       = acc_q;
    val_n       = val_q;
    ovf_n       = 1'b0;
    valid_n     = valid_q;
    dig_ext     = '0;
    dig_ext[3:0] = kdig;
    case (state)
      S_ENTRY: begin
        if (key_down_op) begin
          case (kcls)
            K_DIGIT: begin
              if (cnt_q != FULL) begin
                entry_n = (entry_q << 4) | dig_ext;
                cnt_n   = cnt_q + CW'(1);
              end else begin
                ovf_n = 1'b1;
              end
            end
            K_BKSP: begin
              if (cnt_q != '0) begin
                entry_n = entry_q >> 4;
                cnt_n   = cnt_q - CW'(1);
              end
            end
            K_ESC: begin
              entry_n = '0;
              cnt_n   = '0;
            end
            K_ENTER: begin
              if (cnt_q != '0) begin
                acc_n   = '0;
                idx_n   = cnt_q - CW'(1);
                state_n = S_CONV;
              end
            end
            default: ;
          endcase
        end
      end
      S_CONV: begin
        acc_n = (acc_q << 3) + (acc_q << 1) + VAL_W'(cur_dig);
        if (idx_q == '0) begin
          val_n   = acc_n;
          valid_n = 1'b1;
          state_n = S_HOLD;
        end else begin
          idx_n = idx_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          valid_n = 1'b0;
          entry_n = '0;
          cnt_n   = '0;
          state_n = S_ENTRY;
        end
      end
      default: state_n = S_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_ENTRY;
      entry_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      val_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      entry_q <= entry_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      acc_q   <= acc_n;
      val_q   <= val_n;
      ovf_q   <= ovf_n;
      valid_q <= valid_n;
    end
  end

  assign disp_bcd  = entry_q;
  assign digit_cnt = cnt_q;
  assign busy      = (state != S_ENTRY);
  assign overflow  = ovf_q;
  assign out_valid = valid_q;
  assign out_value = val_q;

endmodule

// File: tb/tb_kb_number_entry_ctrl.sv
// Self-checking bench for kb_number_entry_ctrl: directed scenarios plus randomized key streams.
module tb_kb_number_entry_ctrl;

  localparam int MAXD = 4;
  localparam int VW   = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_down_op = 1'b0;
  logic [8:0]  last_change = '0;
  logic        out_ready = 1'b0;
  logic [15:0] disp_bcd;
  logic [2:0]  digit_cnt;
  logic        busy, overflow, out_valid;
  logic [VW-1:0] out_value;

  int checks = 0;
  int errors = 0;
  int digs[$];

  logic [7:0] top_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pad_codes [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  kb_number_entry_ctrl #(.MAX_DIGITS(MAXD), .VAL_W(VW)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down_op (key_down_op),
    .last_change (last_change),
    .out_ready   (out_ready),
    .disp_bcd    (disp_bcd),
    .digit_cnt   (digit_cnt),
    .busy        (busy),
    .overflow    (overflow),
    .out_valid   (out_valid),
    .out_value   (out_value)
  );

  always #5 clk = ~clk;

  // Reference key classification: 0 none, 1 digit, 2 backspace, 3 enter, 4 esc.
  function automatic int kclass(input logic [8:0] c, output int d);
    d = 0;
    if (c[8] == 1'b0) begin
      for (int i = 0; i < 10; i++) if (c[7:0] == top_codes[i]) begin d = i; return 1; end
`ifdef KB_KEYPAD_DIGITS_EN
      for (int i = 0; i < 10; i++) if (c[7:0] == pad_codes[i]) begin d = i; return 1; end
`endif
      if (c[7:0] == 8'h66) return 2;
      if (c[7:0] == 8'h5A) return 3;
      if (c[7:0] == 8'h76) return 4;
    end
`ifdef KB_KEYPAD_DIGITS_EN
    else if (c[7:0] == 8'h5A) return 3;
`endif
    return 0;
  endfunction

  function automatic logic [15:0] exp_disp();
    logic [15:0] r = '0;
    foreach (digs[i]) r = (r << 4) | 16'(digs[i]);
    return r;
  endfunction

  function automatic int exp_value();
    int v = 0;
    foreach (digs[i]) v = v * 10 + digs[i];
    return v;
  endfunction

  function automatic logic [8:0] dkey(input int d);
    return {1'b0, top_codes[d]};
  endfunction

  task automatic press(input logic [8:0] c);
    @(negedge clk);
    last_change = c;
    key_down_op = 1'b1;
    @(negedge clk);
    key_down_op = 1'b0;
    last_change = '0;
  endtask

  // Counts negedges until out_valid is seen; n = -1 if the limit expires.
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) n = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    digs.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({disp_bcd, digit_cnt, busy, overflow, out_valid, out_value} !== '0) begin
      errors++;
      $display("FAIL reset_state: disp=%h cnt=%0d busy=%b ovf=%b valid=%b val=%0d, want all zero",
               disp_bcd, digit_cnt, busy, overflow, out_valid, out_value);
    end
  endtask

  task automatic test_basic();
    int n;
    press(dkey(1)); press(dkey(2)); press(dkey(3));
    checks++;
    if (disp_bcd !== 16'h0123 || digit_cnt !== 3'd3) begin
      errors++;
      $display("FAIL basic_entry: disp=%h cnt=%0d, want 0123 cnt=3", disp_bcd, digit_cnt);
    end
    press(9'h05A);
    wait_valid(20, n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL basic_latency: extra cycles=%0d, want 3", n); end
    checks++;
    if (out_value !== VW'(123) || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_value: val=%0d busy=%b, want 123 busy=1", out_value, busy);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || disp_bcd !== 16'h0 || digit_cnt !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: valid=%b disp=%h cnt=%0d busy=%b, want 0 0 0 0",
               out_valid, disp_bcd, digit_cnt, busy);
    end
  endtask

  task automatic test_overflow();
    int n;
    repeat (4) press(dkey(9));
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: ovf=%b, want 0", overflow); end
    press(dkey(5));
    checks++;
    if (overflow !== 1'b1 || disp_bcd !== 16'h9999 || digit_cnt !== 3'd4) begin
      errors++;
      $display("FAIL ovf_pulse: ovf=%b disp=%h cnt=%0d, want 1 9999 4", overflow, disp_bcd, digit_cnt);
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_width: ovf=%b, want 0", overflow); end
    press(9'h05A);
    wait_valid(20, n);
    checks++;
    if (n != 4 || out_value !== VW'(9999)) begin
      errors++;
      $display("FAIL ovf_value: cycles=%0d val=%0d, want 4 9999", n, out_value);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backspace();
    int n;
    int exp_cnt [3] = '{1, 0, 0};
    press(dkey(4)); press(dkey(5));
    checks++;
    if (digit_cnt !== 3'd2) begin errors++; $display("FAIL bksp_start: cnt=%0d, want 2", digit_cnt); end
    for (int i = 0; i < 3; i++) begin
      press(9'h066);
      checks++;
      if (digit_cnt !== 3'(exp_cnt[i])) begin
        errors++;
        $display("FAIL bksp_cnt: step=%0d cnt=%0d, want %0d", i, digit_cnt, exp_cnt[i]);
      end
    end
    checks++;
    if (disp_bcd !== 16'h0) begin errors++; $display("FAIL bksp_disp: disp=%h, want 0", disp_bcd); end
    press(9'h05A);
    wait_valid(10, n);
    checks++;
    if (n != -1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_enter: valid seen after %0d busy=%b, want none busy=0", n, busy);
    end
  endtask

  task automatic test_hold();
    int n;
    press(dkey(0)); press(dkey(7)); press(9'h05A);
    wait_valid(20, n);
    checks++;
    if (n != 2) begin errors++; $display("FAIL hold_latency: cycles=%0d, want 2", n); end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) press(dkey(8));
      else if (i == 9) press(9'h076);
      else @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_value !== VW'(7)) begin
        errors++;
        $display("FAIL hold_stable: cycle=%0d valid=%b val=%0d, want 1 7", i, out_valid, out_value);
      end
    end
    checks++;
    if (disp_bcd !== 16'h0007 || digit_cnt !== 3'd2) begin
      errors++;
      $display("FAIL hold_keys: disp=%h cnt=%0d, want 0007 2", disp_bcd, digit_cnt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL hold_ack: valid=%b cnt=%0d, want 0 0", out_valid, digit_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    press(dkey(5)); press(dkey(6)); press(dkey(7)); press(dkey(8)); press(9'h05A);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({disp_bcd, digit_cnt, busy, overflow, out_valid, out_value} !== '0) begin
      errors++;
      $display("FAIL reset_mid: disp=%h cnt=%0d busy=%b ovf=%b valid=%b val=%0d, want all zero",
               disp_bcd, digit_cnt, busy, overflow, out_valid, out_value);
    end
    wait_valid(10, n);
    checks++;
    if (n != -1) begin errors++; $display("FAIL reset_mid_valid: valid after %0d, want none", n); end
    digs.delete();
  endtask

  task automatic test_keypad();
    int n;
    press(9'h069);
    press(9'h05A);
`ifdef KB_KEYPAD_DIGITS_EN
    wait_valid(20, n);
    checks++;
    if (n != 1 || out_value !== VW'(1)) begin
      errors++;
      $display("FAIL keypad_value: cycles=%0d val=%0d, want 1 1", n, out_value);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
`else
    checks++;
    if (digit_cnt !== 3'd0 || disp_bcd !== 16'h0) begin
      errors++;
      $display("FAIL keypad_ignored: cnt=%0d disp=%h, want 0 0", digit_cnt, disp_bcd);
    end
    wait_valid(10, n);
    checks++;
    if (n != -1) begin errors++; $display("FAIL keypad_novalid: valid after %0d, want none", n); end
`endif
  endtask

  task automatic test_random();
    logic [8:0] c;
    int cls, d, n, ev, nd;
    bit ovf_exp, early;
    press(9'h076);
    digs.delete();
    for (int step = 0; step < 300; step++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: c = dkey($urandom_range(0, 9));
        4:       c = {1'b0, pad_codes[$urandom_range(0, 9)]};
        5:       c = 9'h066;
        6:       c = ($urandom_range(0, 3) == 0) ? 9'h076 : {1'b1, top_codes[$urandom_range(0, 9)]};
        7:       c = ($urandom_range(0, 1) == 0) ? 9'h05A : 9'h15A;
        8:       c = 9'h05A;
        default: c = 9'($urandom_range(0, 511));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      cls = kclass(c, d);
      ovf_exp = 1'b0;
      ev = 0;
      nd = digs.size();
      case (cls)
        1: if (digs.size() < MAXD) digs.push_back(d); else ovf_exp = 1'b1;
        2: if (digs.size() > 0) void'(digs.pop_back());
        3: if (digs.size() > 0) ev = exp_value();
        4: digs.delete();
        default: ;
      endcase
      press(c);
      if (cls == 3 && nd > 0) begin
        early = 1'($urandom_range(0, 1));
        if (early) out_ready = 1'b1;
        wait_valid(20, n);
        checks++;
        if (n != nd || out_value !== VW'(ev) || disp_bcd !== exp_disp()) begin
          errors++;
          $display("FAIL rand_conv: step=%0d cycles=%0d val=%0d disp=%h, want %0d %0d %h",
                   step, n, out_value, disp_bcd, nd, ev, exp_disp());
        end
        if (!early) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        digs.delete();
        checks++;
        if (out_valid !== 1'b0 || digit_cnt !== 3'd0 || disp_bcd !== 16'h0) begin
          errors++;
          $display("FAIL rand_ack: step=%0d valid=%b cnt=%0d disp=%h, want 0 0 0",
                   step, out_valid, digit_cnt, disp_bcd);
        end
      end else begin
        checks++;
        if (disp_bcd !== exp_disp() || digit_cnt !== 3'(digs.size()) || overflow !== ovf_exp
            || busy !== 1'b0) begin
          errors++;
          $display("FAIL rand_entry: step=%0d code=%h disp=%h cnt=%0d ovf=%b busy=%b, want %h %0d %b 0",
                   step, c, disp_bcd, digit_cnt, overflow, busy, exp_disp(), digs.size(), ovf_exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backspace();
    test_hold();
    test_reset_mid();
    test_keypad();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
